interp_time_seq: RTL and testbench

//  Upstream time-interpolation sequencer for the channel-estimation equaliser path.

---
 rtl/interp_pkg.sv | 27 ++
 rtl/interp_time_seq_div3_pipe.sv | 72 +++++++
 rtl/interp_time_seq.sv | 95 +++++++++
 tb/tb_interp_time_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// Shared constants for the time-interpolation sequencer: select codes, 1/3 multiplier,
// per-symbol select schedule and FSM states. Build option INTERP_ROUND_EN lives in div3_pipe.
package interp_pkg;

  localparam logic [1:0] SEL_EST3 = 2'b01;
  localparam logic [1:0] SEL_DIV1 = 2'b10;
  localparam logic [1:0] SEL_DIV2 = 2'b00;
  localparam logic [1:0] SEL_EST4 = 2'b11;

  // ceil(2^16/3): x/3 ~= (x*K_DIV3) >>> 16
  localparam int K_DIV3 = 21846;

  localparam logic [1:0] SEL_TABLE [0:13] = '{
    SEL_EST3, SEL_EST3, SEL_EST3, SEL_EST3, SEL_EST3, SEL_EST3,
    SEL_DIV1, SEL_DIV1, SEL_DIV1,
    SEL_DIV2, SEL_DIV2,
    SEL_EST4, SEL_EST4, SEL_EST4
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUM,
    ST_MUL,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/interp_time_seq_div3_pipe.sv
// Two-stage (SUM, MUL) computation of (2*e3+e4)/3 and (e3+2*e4)/3.
// INTERP_ROUND_EN defined: round half up; otherwise floor.
module div3_pipe
  import interp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] e3,
  input  logic [WIDTH-1:0] e4,
  output logic             out_valid,
  output logic [WIDTH-1:0] res1,
  output logic [WIDTH-1:0] res2
);

  localparam int SW = WIDTH + 2;
  localparam int PW = 2 * WIDTH + 4;
  localparam logic signed [PW-1:0] Q_MAX = PW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] Q_MIN = -Q_MAX - PW'(1);

  logic signed [SW-1:0] e3_x, e4_x;
  logic signed [SW-1:0] s1_reg, s2_reg;
  logic                 v1_reg;

  assign e3_x = SW'($signed(e3));
  assign e4_x = SW'($signed(e4));

  // K_DIV3 is rounded up, so full-scale inputs can land one LSB outside the range; clamp.
  function automatic logic [WIDTH-1:0] div3(input logic signed [SW-1:0] s);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] q;
    logic [WIDTH-1:0]     r;
    p = PW'(s) * PW'(K_DIV3);
`ifdef INTERP_ROUND_EN
    p = p + (PW'(1) <<< 15);
`else
    p = p + PW'(0);
`endif
    q = p >>> 16;
    if (q > Q_MAX) r = Q_MAX[WIDTH-1:0];
    else if (q < Q_MIN) r = Q_MIN[WIDTH-1:0];
    else r = q[WIDTH-1:0];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_reg    <= '0;
      s2_reg    <= '0;
      v1_reg    <= 1'b0;
      out_valid <= 1'b0;
      res1      <= '0;
      res2      <= '0;
    end else begin
      v1_reg <= in_valid;
      if (in_valid) begin
        s1_reg    <= e3_x + e3_x + e4_x;
        s2_reg    <= e3_x + e4_x + e4_x;
        out_valid <= 1'b0;
      end
      // results stay put (and valid) until the next pair enters
      if (v1_reg) begin
        res1      <= div3(s1_reg);
        res2      <= div3(s2_reg);
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/interp_time_seq.sv
// Time-interpolation sequencer: accepts an (est3, est4) pair, computes the 1/3 interpolants
// and walks NUM_SYM symbols emitting the h_eqlz_2 mux select. Rounding via INTERP_ROUND_EN.
module interp_time_seq
  import interp_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_SYM = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] est3,
  input  logic [WIDTH-1:0] est4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic [3:0]       sym_idx,
  output logic [WIDTH-1:0] est3_q,
  output logic [WIDTH-1:0] est4_q,
  output logic [WIDTH-1:0] div_res_1,
  output logic [WIDTH-1:0] div_res_2,
  output logic             last
);

  state_t     state_reg;
  logic       emit_reg;
  logic       div_valid;
  logic [3:0] sym_next;

  assign sym_next  = sym_idx + 4'd1;
  assign out_valid = emit_reg & div_valid;

  div3_pipe #(.WIDTH(WIDTH)) u_div3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (state_reg == ST_SUM),
    .e3        (est3_q),
    .e4        (est4_q),
    .out_valid (div_valid),
    .res1      (div_res_1),
    .res2      (div_res_2)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      in_ready  <= 1'b1;
      emit_reg  <= 1'b0;
      sel       <= 2'b00;
      sym_idx   <= 4'd0;
      last      <= 1'b0;
      est3_q    <= '0;
      est4_q    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            est3_q    <= est3;
            est4_q    <= est4;
            in_ready  <= 1'b0;
            state_reg <= ST_SUM;
          end
        end
        ST_SUM: state_reg <= ST_MUL;
        ST_MUL: begin
          emit_reg  <= 1'b1;
          sym_idx   <= 4'd0;
          sel       <= SEL_TABLE[0];
          last      <= (NUM_SYM == 1);
          state_reg <= ST_EMIT;
        end
        ST_EMIT: begin
          // a stalled beat leaves every output register untouched
          if (out_ready) begin
            if (last) begin
              emit_reg  <= 1'b0;
              in_ready  <= 1'b1;
              sym_idx   <= 4'd0;
              sel       <= 2'b00;
              last      <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              sym_idx <= sym_next;
              sel     <= SEL_TABLE[sym_next];
              last    <= (sym_next == 4'(NUM_SYM - 1));
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interp_time_seq.sv
// Self-checking bench for interp_time_seq: table of estimate pairs with hand-computed
// interpolants, plus backpressure and mid-run reset sequences.
module tb_interp_time_seq;

  localparam int W   = 16;
  localparam int NUM = 14;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] est3 = '0;
  logic [W-1:0] est4 = '0;
  logic         in_ready, out_valid, last;
  logic [1:0]   sel;
  logic [3:0]   sym_idx;
  logic [W-1:0] est3_q, est4_q, div_res_1, div_res_2;

  int checks = 0;
  int failures = 0;

  interp_time_seq #(.WIDTH(W), .NUM_SYM(NUM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .est3      (est3),
    .est4      (est4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .sym_idx   (sym_idx),
    .est3_q    (est3_q),
    .est4_q    (est4_q),
    .div_res_1 (div_res_1),
    .div_res_2 (div_res_2),
    .last      (last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [W-1:0] e3;
    logic signed [W-1:0] e4;
    logic signed [W-1:0] d1;
    logic signed [W-1:0] d2;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int exp_sel(input int b);
    if (b < 6) return 1;
    else if (b < 9) return 2;
    else if (b < 11) return 0;
    else return 3;
  endfunction

  task automatic run_pair(input int idx, input bit toggle);
    int k;
    int beats;
    int cyc;
    @(negedge clk);
    chk("in_ready_idle", int'(in_ready), 1);
    in_valid = 1'b1;
    est3 = vecs[idx].e3;
    est4 = vecs[idx].e4;
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_busy", int'(in_ready), 0);
    k = 1;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, 3);
    chk("est3_q", int'($signed(est3_q)), int'(vecs[idx].e3));
    chk("est4_q", int'($signed(est4_q)), int'(vecs[idx].e4));
    beats = 0;
    cyc = 0;
    while (beats < NUM && cyc < 64) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      chk("out_valid", int'(out_valid), 1);
      chk("sym_idx", int'(sym_idx), beats);
      chk("sel", int'(sel), exp_sel(beats));
      chk("last", int'(last), (beats == NUM - 1) ? 1 : 0);
      chk("div_res_1", int'($signed(div_res_1)), int'(vecs[idx].d1));
      chk("div_res_2", int'($signed(div_res_2)), int'(vecs[idx].d2));
      chk("in_ready_emit", int'(in_ready), 0);
      if (out_ready) beats++;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("emit_cycles", cyc, toggle ? 2 * NUM - 1 : NUM);
    chk("done_out_valid", int'(out_valid), 0);
    chk("done_in_ready", int'(in_ready), 1);
    $display("txn vec=%0d est3=%0d est4=%0d div_res_1=%0d div_res_2=%0d toggle=%0d cycles=%0d",
             idx, vecs[idx].e3, vecs[idx].e4, $signed(div_res_1), $signed(div_res_2), toggle, cyc);
  endtask

  initial begin
    vecs[0] = '{e3: 16'sd300,    e4: 16'sd0,      d1: 16'sd200,    d2: 16'sd100};
`ifdef INTERP_ROUND_EN
    vecs[1] = '{e3: -16'sd3,     e4: 16'sd6,      d1: 16'sd0,      d2: 16'sd3};
    vecs[2] = '{e3: 16'sd1,      e4: 16'sd0,      d1: 16'sd1,      d2: 16'sd0};
    vecs[5] = '{e3: 16'sd100,    e4: 16'sd200,    d1: 16'sd133,    d2: 16'sd167};
    vecs[6] = '{e3: -16'sd300,   e4: 16'sd0,      d1: -16'sd200,   d2: -16'sd100};
`else
    vecs[1] = '{e3: -16'sd3,     e4: 16'sd6,      d1: 16'sd0,      d2: 16'sd3};
    vecs[2] = '{e3: 16'sd1,      e4: 16'sd0,      d1: 16'sd0,      d2: 16'sd0};
    vecs[5] = '{e3: 16'sd100,    e4: 16'sd200,    d1: 16'sd133,    d2: 16'sd166};
    vecs[6] = '{e3: -16'sd300,   e4: 16'sd0,      d1: -16'sd201,   d2: -16'sd101};
`endif
    vecs[3] = '{e3: 16'sd32767,  e4: 16'sd32767,  d1: 16'sd32767,  d2: 16'sd32767};
    vecs[4] = '{e3: -16'sd32768, e4: -16'sd32768, d1: -16'sd32768, d2: -16'sd32768};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sym_idx", int'(sym_idx), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_div_res_1", int'(div_res_1), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_pair(i, 1'b0);

    // backpressure: out_ready alternates 1/0, outputs must hold through stalls
    run_pair(5, 1'b1);

    // reset mid-emission at sym_idx 7
    @(negedge clk);
    in_valid = 1'b1;
    est3 = 16'sd300;
    est4 = 16'sd0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    for (int b = 0; b < 7; b++) @(negedge clk);
    out_ready = 1'b0;
    chk("pre_rst_sym_idx", int'(sym_idx), 7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_sym_idx", int'(sym_idx), 0);
    chk("mid_rst_div_res_1", int'(div_res_1), 0);
    chk("mid_rst_est3_q", int'(est3_q), 0);
    repeat (3) @(negedge clk);
    chk("post_rst_out_valid", int'(out_valid), 0);
    run_pair(1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
